// File: rtl/id_decode_queue.sv
// id_decode_queue: RV32I decode stage with a DEPTH-entry FIFO sitting between
// fetch and execute. Every instruction is decoded as it is pushed, and the
// decoded record is stored. The head entry drives the out_* fields.
//
// Optional build macro: ID_ILLEGAL_CHECK_EN. When it is defined, out_illegal
// flags unrecognised or malformed encodings. When it is not defined,
// out_illegal is tied to 0.
module id_decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [6:0]                 out_opcode,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [2:0]                 out_funct3,
    output logic [6:0]                 out_funct7,
    output logic [31:0]                out_imm,
    output logic [2:0]                 out_fmt,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH+1);
    // Each entry holds pc, opcode, rd, rs1, rs2, funct3, funct7, imm, fmt
    // and illegal.
    localparam int ENTRY_W = PC_W + 7 + 5 + 5 + 5 + 3 + 7 + 32 + 3 + 1;

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // ------------------------------------------------------------------
    // Decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  d_fmt;
    logic [4:0]  d_rd;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic [2:0]  d_funct3;
    logic [6:0]  d_funct7;
    logic [31:0] d_imm;
    logic        d_illegal;

    assign opcode = in_instr[6:0];

    // Classify the format and extract only the fields that format uses.
    // All other fields stay at their zero defaults.
    always_comb begin
        d_fmt    = FMT_NONE;
        d_rd     = 5'd0;
        d_rs1    = 5'd0;
        d_rs2    = 5'd0;
        d_funct3 = 3'd0;
        d_funct7 = 7'd0;
        d_imm    = 32'd0;
        case (opcode)
            OP_REG: begin
                d_fmt    = FMT_R;
                d_rd     = in_instr[11:7];
                d_rs1    = in_instr[19:15];
                d_rs2    = in_instr[24:20];
                d_funct3 = in_instr[14:12];
                d_funct7 = in_instr[31:25];
            end
            OP_IMM, OP_LOAD, OP_JALR, OP_SYS: begin
                d_fmt    = FMT_I;
                d_rd     = in_instr[11:7];
                d_rs1    = in_instr[19:15];
                d_funct3 = in_instr[14:12];
                d_imm    = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_STORE: begin
                d_fmt    = FMT_S;
                d_rs1    = in_instr[19:15];
                d_rs2    = in_instr[24:20];
                d_funct3 = in_instr[14:12];
                d_imm    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OP_BR: begin
                d_fmt    = FMT_B;
                d_rs1    = in_instr[19:15];
                d_rs2    = in_instr[24:20];
                d_funct3 = in_instr[14:12];
                d_imm    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                d_fmt    = FMT_U;
                d_rd     = in_instr[11:7];
                d_imm    = {in_instr[31:12], 12'd0};
            end
            OP_JAL: begin
                d_fmt    = FMT_J;
                d_rd     = in_instr[11:7];
                d_imm    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            end
            default: begin
                d_fmt    = FMT_NONE;
            end
        endcase
    end

`ifdef ID_ILLEGAL_CHECK_EN
    // Flag an unknown opcode, a non-32-bit encoding, or an R-type funct7
    // outside the two values that base RV32I uses.
    always_comb begin
        d_illegal = 1'b0;
        if (d_fmt == FMT_NONE || in_instr[1:0] != 2'b11)
            d_illegal = 1'b1;
        else if (d_fmt == FMT_R && in_instr[31:25] != 7'b0000000
                 && in_instr[31:25] != 7'b0100000)
            d_illegal = 1'b1;
    end
`else
    assign d_illegal = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Queue storage and control
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt_q;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] wr_entry;

    // Ready and valid depend only on the registered count. This keeps
    // out_ready from reaching in_ready combinationally.
    assign in_ready  = (cnt_q < CNT_W'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = cnt_q;

    assign wr_entry = {in_pc, opcode, d_rd, d_rs1, d_rs2, d_funct3,
                       d_funct7, d_imm, d_fmt, d_illegal};

    // Entry storage. It is cleared on reset so that the head fields read
    // as 0 out of reset. A push in a flush cycle is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push && !flush_i) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointer and occupancy update. Flush takes priority over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // The head entry drives the execute-side fields. These fields stay
    // stable until the entry is popped.
    assign {out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_funct3,
            out_funct7, out_imm, out_fmt, out_illegal} = mem[rd_ptr];

endmodule

// File: tb/tb_id_decode_queue.sv
// Testbench for id_decode_queue. The decode checks are driven from a vector
// table. Separate sequences cover ordering, a full queue, flush and a reset
// in the middle of operation.
module tb_id_decode_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
`ifdef ID_ILLEGAL_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    id_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        ill;   // value expected when illegal checking is built in
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_one(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] ins;
        logic [31:0] exp_pc;
        logic        rdy_b;
        int          pushed;
        int          popped;

        vecs[0]  = '{32'h00500093, 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000005, 1'b0};
        vecs[1]  = '{32'hFE208EE3, 3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC, 1'b0};
        vecs[2]  = '{32'h123452B7, 3'd4, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 1'b0};
        vecs[3]  = '{32'h008000EF, 3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000008, 1'b0};
        vecs[4]  = '{32'hFFFFFFFF, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1};
        vecs[5]  = '{32'h002081B3, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000000, 1'b0};
        vecs[6]  = '{32'h402081B3, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h00000000, 1'b0};
        vecs[7]  = '{32'h022081B3, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h01, 32'h00000000, 1'b1};
        vecs[8]  = '{32'h0020A423, 3'd2, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h00000008, 1'b0};
        vecs[9]  = '{32'hFE20AE23, 3'd2, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFFFFFC, 1'b0};
        vecs[10] = '{32'hFFF12283, 3'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'h00, 32'hFFFFFFFF, 1'b0};
        vecs[11] = '{32'h80000397, 3'd4, 5'd7, 5'd0, 5'd0, 3'd0, 7'h00, 32'h80000000, 1'b0};
        vecs[12] = '{32'h00000001, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1};
        vecs[13] = '{32'h00000073, 3'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b0};
        vecs[14] = '{32'hFF9FF06F, 3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFF8, 1'b0};

        rst_n = 1'b0; flush_i = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_fmt", 64'(out_fmt), 64'd0);
        chk("rst_imm", 64'(out_imm), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_illegal", 64'(out_illegal), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven decode. Each push is checked one cycle later and then popped.
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            ins    = vecs[i].instr;
            exp_pc = 32'h100 + 32'(4 * i);
            chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
            push_one(ins, exp_pc);
            chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d_pc", i), 64'(out_pc), 64'(exp_pc));
            chk($sformatf("v%0d_opcode", i), 64'(out_opcode), 64'(ins[6:0]));
            chk($sformatf("v%0d_fmt", i), 64'(out_fmt), 64'(vecs[i].fmt));
            chk($sformatf("v%0d_rd", i), 64'(out_rd), 64'(vecs[i].rd));
            chk($sformatf("v%0d_rs1", i), 64'(out_rs1), 64'(vecs[i].rs1));
            chk($sformatf("v%0d_rs2", i), 64'(out_rs2), 64'(vecs[i].rs2));
            chk($sformatf("v%0d_f3", i), 64'(out_funct3), 64'(vecs[i].f3));
            chk($sformatf("v%0d_f7", i), 64'(out_funct7), 64'(vecs[i].f7));
            chk($sformatf("v%0d_imm", i), 64'(out_imm), 64'(vecs[i].imm));
            chk($sformatf("v%0d_illegal", i), 64'(out_illegal), 64'(ILL_EN & vecs[i].ill));
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_drained", i), 64'(out_valid), 64'd0);
        end

        // Back-to-back pushes of lui then jal. The queue must keep their order.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h123452B7; in_pc = 32'h400;
        @(posedge clk); @(negedge clk);
        in_instr = 32'h008000EF; in_pc = 32'h404;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_count", 64'(count), 64'd2);
        chk("b2b_first_fmt", 64'(out_fmt), 64'd4);
        chk("b2b_first_rd", 64'(out_rd), 64'd5);
        chk("b2b_first_imm", 64'(out_imm), 64'h12345000);
        @(posedge clk); @(negedge clk);
        chk("b2b_hold_pc", 64'(out_pc), 64'h400);
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_second_fmt", 64'(out_fmt), 64'd5);
        chk("b2b_second_rd", 64'(out_rd), 64'd1);
        chk("b2b_second_imm", 64'(out_imm), 64'h00000008);
        chk("b2b_second_pc", 64'(out_pc), 64'h404);
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("b2b_empty", 64'(count), 64'd0);

        // Fill to DEPTH with the consumer stalled. Fetch offers a fifth instruction.
        out_ready = 1'b0;
        pushed = 0;
        in_instr = 32'h00500093;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_pc = 32'h200 + 32'(4 * pushed);
            rdy_b = in_ready;
            @(posedge clk); @(negedge clk);
            if (rdy_b) pushed++;
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_pushed", 64'(pushed), 64'd4);
        chk("full_head_pc", 64'(out_pc), 64'h200);

        // Drain the queue. The fifth instruction enters once in_ready rises.
        out_ready = 1'b1;
        popped = 0;
        for (int k = 0; k < 12 && popped < 5; k++) begin
            if (k == 0)
                chk("drain_no_passthru", 64'(in_ready), 64'd0);
            if (out_valid) begin
                chk($sformatf("drain_pc%0d", popped), 64'(out_pc), 64'(32'h200 + 32'(4 * popped)));
                popped++;
            end
            in_valid = (pushed < 5);
            in_pc = 32'h200 + 32'(4 * pushed);
            rdy_b = in_ready;
            @(posedge clk); @(negedge clk);
            if (rdy_b && in_valid) pushed++;
        end
        in_valid = 1'b0;
        chk("drain_popped", 64'(popped), 64'd5);
        chk("drain_pushed", 64'(pushed), 64'd5);
        chk("drain_empty", 64'(count), 64'd0);

        // Flush with three entries queued and a push offered in the flush cycle.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            push_one(32'h00500093, 32'h300 + 32'(4 * k));
        chk("flush_pre_count", 64'(count), 64'd3);
        flush_i = 1'b1; in_valid = 1'b1; in_instr = 32'h123452B7; in_pc = 32'h3FC;
        @(posedge clk); @(negedge clk);
        flush_i = 1'b0; in_valid = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); @(negedge clk);
        chk("flush_no_ghost", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        push_one(32'h008000EF, 32'h500);
        chk("flush_after_pc", 64'(out_pc), 64'h500);
        chk("flush_after_fmt", 64'(out_fmt), 64'd5);
        @(posedge clk); @(negedge clk);

        // Reset in the middle of operation drops the queued entries at once.
        out_ready = 1'b0;
        push_one(32'hFFFFFFFF, 32'h600);
        push_one(32'h00500093, 32'h604);
        chk("mrst_pre_count", 64'(count), 64'd2);
        chk("mrst_pre_fmt", 64'(out_fmt), 64'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_count", 64'(count), 64'd0);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_fmt", 64'(out_fmt), 64'd0);
        chk("mrst_pc", 64'(out_pc), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_decode_queue.md
# id_decode_queue

Parametrised decode stage with a built-in instruction queue, successor to the single-register ID stage. It accepts fetched instructions and their PCs over a valid/ready handshake, fully decodes every RV32I base format (R/I/S/B/U/J), stores decoded entries in a DEPTH-entry FIFO and presents the head entry to the execute stage. Fetch/decode decoupling absorbs back-pressure, and pipeline flushes drop all queued work. The block sits between IF and EX in each core.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- PC_W, 32, PC width carried alongside each instruction
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush_i  input  1  discard all queued entries (branch redirect)
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  queue can accept this cycle
- in_instr  input  32  raw instruction
- in_pc  input  PC_W  instruction address
- out_valid  output  1  head entry valid
- out_ready  input  1  execute consumes head this cycle
- out_pc  output  PC_W  head PC
- out_opcode  output  7  instr[6:0]
- out_rd, out_rs1, out_rs2  output  5 each  register indices
- out_funct3  output  3
- out_funct7  output  7
- out_imm  output  32  sign-extended immediate
- out_fmt  output  3  R=0, I=1, S=2, B=3, U=4, J=5, NONE=7
- out_illegal  output  1  unrecognised encoding
- count  output  $clog2(DEPTH+1)  occupied entries

## Operation
- Decode is combinational on in_instr. The decoded record is written to the FIFO on push (in_valid && in_ready).
- Opcode map:
  - 0110011 → R.
  - 0010011, 0000011, 1100111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - Anything else → NONE.
- Fields not used by a format are forced to 0:
  - rd = 0 for S/B.
  - rs1 = 0 for U/J.
  - rs2 = 0 for I/U/J.
  - funct3 = 0 for U/J.
  - funct7 = 0 for all formats except R.
  - For NONE, every field except opcode is 0.
- Immediates:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: {instr[31:12], 12'b0}.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R/NONE: 0.
- FIFO uses read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus an explicit count.
- in_ready = (count < DEPTH). There is no pass-through when full, so in_ready is 0 at count == DEPTH even if out_ready = 1.
- out_valid = (count != 0). All out_* fields are driven from the head entry and are held stable while out_valid && !out_ready.
- Pop = out_valid && out_ready. Simultaneous push and pop leaves count unchanged and advances both pointers.
- flush_i: on the next edge count and both pointers go to 0. A push in the flush cycle is discarded; flush wins over push and pop.
- Reset mid-operation: all queued entries are lost immediately (asynchronous).

## Timing
- Reset values: count = 0, in_ready = 1, out_valid = 0, all out_* data fields = 0, out_fmt = 0, out_illegal = 0.
- Latency: a push at edge N with an empty queue gives out_valid = 1 in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- in_ready and out_valid depend only on registered state (count). There is no combinational path from out_ready to in_ready.
- flush_i asserted in cycle N gives out_valid = 0 and count = 0 in cycle N+1.

## Configuration
- ID_ILLEGAL_CHECK_EN defined:
  - out_illegal = 1 for out_fmt NONE, or when instr[1:0] != 2'b11.
  - Also set for R-type with funct7 not in {0000000, 0100000}.
  - The entry still flows through the queue normally.
- Undefined: the out_illegal output exists but is tied to 0. out_fmt NONE decoding is unchanged.

## Test plan
- Push 0x00500093 (addi x1,x0,5) with pc 0x100, out_ready = 1 → next cycle out_fmt = 1, rd = 1, rs1 = 0, rs2 = 0, imm = 0x00000005, out_pc = 0x100.
- Push 0xFE208EE3 (beq x1,x2,-4) → out_fmt = 3, rs1 = 1, rs2 = 2, rd = 0, funct3 = 0, imm = 0xFFFFFFFC.
- Push 0x123452B7 (lui x5) then 0x008000EF (jal x1,8) back-to-back:
  - First: fmt 4, rd = 5, imm = 0x12345000.
  - Second: fmt 5, rd = 1, imm = 0x00000008.
  - Order is preserved.
- DEPTH = 4, out_ready = 0, push 5 instructions:
  - in_ready drops after the 4th; count = 4; the 5th is held by fetch.
  - Then out_ready = 1: four pops in order, and the 5th enters the cycle in_ready rises.
- Queue holding 3 entries, assert flush_i together with in_valid → next cycle count = 0 and out_valid = 0; the flush-cycle instruction never appears.
- Push 0xFFFFFFFF:
  - out_fmt = 7 and all fields 0.
  - out_illegal = 1 with ID_ILLEGAL_CHECK_EN, 0 without.
